pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Parametrised program-counter sequencer for the RISC-V fetch stage. It generates the fetch address and tracks the address of the instruction now in execute. It resolves conditional branches internally from operand values. It handles JAL/JALR redirects, a single-level trap/return path with a saved exception PC, and misaligned-target detection. A registered flush pulse lets downstream stages squash wrong-path instructions.

## Interface
- XLEN, 32: address/data width.
- RESET_VECTOR, 32'h240: fetch address after reset.
- MTVEC, 32'h100: trap target address.
- CLK  in  1  clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- stall  in  1  hold fetch; ignored when a redirect is taken.
- br_valid  in  1  conditional branch in execute.
- br_cond  in  3  funct3: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU.
- rs1_val, rs2_val  in  XLEN  branch operands; rs1_val is also the JALR base.
- offset  in  XLEN  sign-extended immediate for branch/JAL/JALR.
- jmp_valid  in  1  unconditional jump in execute.
- jmp_kind  in  1  0 = JAL, 1 = JALR.
- trap_req  in  1  exception/interrupt request.
- mret  in  1  return from trap.
- addr  out  XLEN  current fetch address (registered).
- addr_d  out  XLEN  address of the instruction in execute (registered).
- flush  out  1  one-cycle pulse: addr was redirected this cycle.
- epc  out  XLEN  saved exception PC.
- misalign  out  1  one-cycle pulse: redirect target misaligned, trap taken instead.

## Operation
- Branch taken: br_valid=1 and br_cond satisfied. Compare is on rs1_val/rs2_val. Signed for BLT/BGE, unsigned for BLTU/BGEU. Codes 010/011 are never taken.
- Targets, all computed modulo 2^XLEN:
  - branch/JAL target = addr_d + offset.
  - JALR target = (rs1_val + offset) with bit 0 cleared.
- Misaligned: a computed branch/jump target with bits [1:0] ≠ 0. The redirect becomes a trap: addr←MTVEC, epc←addr_d, misalign=1.
- Next-state priority, highest first:
  1. Reset.
  2. trap_req or misaligned target: addr←MTVEC, epc←addr_d, flush=1.
  3. mret: addr←epc, flush=1.
  4. jmp_valid: addr←target, flush=1.
  5. Taken branch: addr←target, flush=1.
  6. stall: addr, addr_d hold, flush=0.
  7. Sequential: addr←addr+4, flush=0.
- addr_d←addr on every non-stalled edge, redirects included. The flush pulse marks that value as wrong-path.
- epc changes only on trap/misalign. mret does not modify epc.
- Simultaneous trap_req and mret: trap wins and epc is overwritten.
- Reset values: addr=addr_d=RESET_VECTOR, epc=0, flush=0, misalign=0.

## Timing
- All outputs are registered. Request inputs are sampled at edge N; the new addr, flush and misalign are visible after edge N.
- Redirect latency is 1 cycle. flush and misalign are high for exactly the one cycle following the redirect edge.
- Back-to-back redirects each produce a flush pulse, so flush may stay high on consecutive cycles.
- A stall lasting k cycles holds addr and addr_d for k cycles. Fetch resumes with addr+4 on the first unstalled edge.
- Reset asserted mid-stall or together with any redirect: next edge gives the reset values. No flush is raised.
- Wrap-around: addr=0xFFFF_FFFC sequential → 0x0000_0000. There is no error.

## Structure
- Package pc_pkg holds:
  - br_cond localparams (BEQ…BGEU).
  - jmp_kind codes.
  - ILEN_BYTES=4.
  - Alignment mask.
- Sub-module pc_branch_cmp (combinational): inputs br_cond, rs1_val, rs2_val; output taken.
- Top holds the addr/addr_d/epc registers, target muxing, the priority logic and the misalign check.

## Test plan
All scenarios use XLEN=32, RESET_VECTOR=0x240, MTVEC=0x100.
- Reset, then 3 free cycles → addr 0x240, 0x244, 0x248, 0x24C; flush=0 throughout.
- addr_d=0x248, BNE with rs1=5, rs2=3, offset=-8 → addr=0x240, flush=1 for one cycle. The same case with BEQ → addr advances sequentially, flush=0.
- rs1=0xFFFF_FFFF, rs2=1 → BLT taken, BLTU not taken, BGEU taken.
- JALR with rs1=0x301, offset=0x10 → addr=0x310.
- JAL with offset=2 at addr_d=0x248 → addr=0x100, epc=0x248, misalign=1 for one cycle.
- trap_req and jmp_valid in the same cycle → addr=0x100, epc=addr_d. A later mret → addr=epc, flush=1.
- stall held 3 cycles at addr=0x250 → addr stays 0x250. Reset raised in the second stall cycle → addr=0x240, flush=0 on the next edge.

Source files
------------

// File: rtl/pc_pkg.sv
// pc_pkg: shared constants, the next-address selection type and a small
// alignment helper for the program-counter sequencer.
//
// Contents:
//   BR_*        conditional-branch funct3 codes
//   JMP_*       jump-kind codes (JAL / JALR)
//   ILEN_BYTES  instruction length in bytes (sequential increment)
//   ALIGN_MASK  low address bits that must be zero for a legal target
//   pc_sel_e    which source feeds the next fetch address
//   is_misaligned()  alignment check on the low target bits
package pc_pkg;

    // Conditional branch conditions (funct3). Codes 010/011 are unused.
    localparam logic [2:0] BR_BEQ  = 3'b000;
    localparam logic [2:0] BR_BNE  = 3'b001;
    localparam logic [2:0] BR_BLT  = 3'b100;
    localparam logic [2:0] BR_BGE  = 3'b101;
    localparam logic [2:0] BR_BLTU = 3'b110;
    localparam logic [2:0] BR_BGEU = 3'b111;

    // Unconditional jump kinds.
    localparam logic JMP_JAL  = 1'b0;
    localparam logic JMP_JALR = 1'b1;

    // Fetch granule and alignment requirement.
    localparam int         ILEN_BYTES = 4;
    localparam logic [1:0] ALIGN_MASK = 2'b11;

    // Source selected for the next fetch address, in priority order.
    typedef enum logic [2:0] {
        SEL_TRAP   = 3'd0,
        SEL_MRET   = 3'd1,
        SEL_JUMP   = 3'd2,
        SEL_BRANCH = 3'd3,
        SEL_HOLD   = 3'd4,
        SEL_SEQ    = 3'd5
    } pc_sel_e;

    // A target is misaligned when any of its low alignment bits is set.
    function automatic logic is_misaligned(input logic [1:0] low_bits);
        return |(low_bits & ALIGN_MASK);
    endfunction

endpackage

// File: rtl/pc_branch_cmp.sv
// pc_branch_cmp: purely combinational branch-condition evaluator.
//
// Ports:
//   br_cond  in  3     funct3 of the conditional branch
//   rs1_val  in  XLEN  first operand
//   rs2_val  in  XLEN  second operand
//   taken    out 1     condition holds (not qualified by br_valid)
module pc_branch_cmp
    import pc_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      br_cond,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    output logic            taken
);

    logic eq_s;
    logic lt_signed_s;
    logic lt_unsigned_s;

    assign eq_s          = (rs1_val == rs2_val);
    assign lt_signed_s   = ($signed(rs1_val) < $signed(rs2_val));
    assign lt_unsigned_s = (rs1_val < rs2_val);

    // Select the comparison result for the requested condition.
    always_comb begin
        taken = 1'b0;
        case (br_cond)
            BR_BEQ:  taken = eq_s;
            BR_BNE:  taken = !eq_s;
            BR_BLT:  taken = lt_signed_s;
            BR_BGE:  taken = !lt_signed_s;
            BR_BLTU: taken = lt_unsigned_s;
            BR_BGEU: taken = !lt_unsigned_s;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-stage program-counter sequencer.
//
// Produces the next fetch address, tracks the address of the instruction in
// execute, resolves conditional branches, handles JAL/JALR, a single-level
// trap/mret path with a saved exception PC, and traps on misaligned targets.
//
// Ports:
//   CLK        in  1     clock, all state updates on the rising edge
//   Reset      in  1     synchronous active-high reset
//   stall      in  1     hold fetch (overridden by any redirect)
//   br_valid   in  1     conditional branch in execute
//   br_cond    in  3     branch funct3
//   rs1_val    in  XLEN  branch operand / JALR base
//   rs2_val    in  XLEN  branch operand
//   offset     in  XLEN  sign-extended immediate
//   jmp_valid  in  1     unconditional jump in execute
//   jmp_kind   in  1     0 = JAL, 1 = JALR
//   trap_req   in  1     exception / interrupt request
//   mret       in  1     return from trap
//   addr       out XLEN  fetch address (registered)
//   addr_d     out XLEN  address of the instruction in execute (registered)
//   flush      out 1     pulse: addr was redirected on the last edge
//   epc        out XLEN  saved exception PC
//   misalign   out 1     pulse: redirect target was misaligned, trap taken
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0240,
    parameter logic [XLEN-1:0] MTVEC        = 32'h0000_0100
) (
    input  logic            CLK,
    input  logic            Reset,
    input  logic            stall,
    input  logic            br_valid,
    input  logic [2:0]      br_cond,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [XLEN-1:0] offset,
    input  logic            jmp_valid,
    input  logic            jmp_kind,
    input  logic            trap_req,
    input  logic            mret,
    output logic [XLEN-1:0] addr,
    output logic [XLEN-1:0] addr_d,
    output logic            flush,
    output logic [XLEN-1:0] epc,
    output logic            misalign
);

    localparam logic [XLEN-1:0] STEP_BYTES = XLEN'(ILEN_BYTES);
    localparam logic [XLEN-1:0] JALR_MASK  = ~{{(XLEN-1){1'b0}}, 1'b1};

    // State registers.
    logic [XLEN-1:0] addr_r;
    logic [XLEN-1:0] addr_d_r;
    logic [XLEN-1:0] epc_r;
    logic            flush_r;
    logic            misalign_r;

    // Combinational decode.
    logic            cmp_taken_s;
    logic            br_taken_s;
    logic [XLEN-1:0] rel_target_s;
    logic [XLEN-1:0] jalr_sum_s;
    logic [XLEN-1:0] jalr_target_s;
    logic [XLEN-1:0] jmp_target_s;
    logic [XLEN-1:0] redir_target_s;
    logic            redir_req_s;
    logic            misalign_s;
    pc_sel_e         sel_s;

    // Next-state values.
    logic [XLEN-1:0] addr_nxt_s;
    logic [XLEN-1:0] addr_d_nxt_s;
    logic [XLEN-1:0] epc_nxt_s;
    logic            flush_nxt_s;

    pc_branch_cmp #(
        .XLEN (XLEN)
    ) u_branch_cmp (
        .br_cond (br_cond),
        .rs1_val (rs1_val),
        .rs2_val (rs2_val),
        .taken   (cmp_taken_s)
    );

    assign br_taken_s    = br_valid & cmp_taken_s;
    // Branch and JAL are both PC-relative to the instruction in execute.
    assign rel_target_s  = addr_d_r + offset;
    assign jalr_sum_s    = rs1_val + offset;
    assign jalr_target_s = jalr_sum_s & JALR_MASK;
    assign jmp_target_s  = (jmp_kind == JMP_JALR) ? jalr_target_s : rel_target_s;

    // Pick the control-flow target that would be taken (jump beats branch)
    // and check it for alignment; a bad target turns into a trap.
    always_comb begin
        redir_req_s    = 1'b0;
        redir_target_s = rel_target_s;
        if (jmp_valid) begin
            redir_req_s    = 1'b1;
            redir_target_s = jmp_target_s;
        end else if (br_taken_s) begin
            redir_req_s    = 1'b1;
            redir_target_s = rel_target_s;
        end else begin
            redir_req_s    = 1'b0;
            redir_target_s = rel_target_s;
        end
        misalign_s = redir_req_s & is_misaligned(redir_target_s[1:0]);
    end

    // Priority encoder for the next-address source.
    always_comb begin
        sel_s = SEL_SEQ;
        if (trap_req || misalign_s) begin
            sel_s = SEL_TRAP;
        end else if (mret) begin
            sel_s = SEL_MRET;
        end else if (jmp_valid) begin
            sel_s = SEL_JUMP;
        end else if (br_taken_s) begin
            sel_s = SEL_BRANCH;
        end else if (stall) begin
            sel_s = SEL_HOLD;
        end else begin
            sel_s = SEL_SEQ;
        end
    end

    // Next-state values for addr, addr_d, epc and flush.
    always_comb begin
        addr_nxt_s   = addr_r + STEP_BYTES;
        addr_d_nxt_s = addr_r;
        epc_nxt_s    = epc_r;
        flush_nxt_s  = 1'b0;
        case (sel_s)
            SEL_TRAP: begin
                addr_nxt_s  = MTVEC;
                epc_nxt_s   = addr_d_r;
                flush_nxt_s = 1'b1;
            end
            SEL_MRET: begin
                addr_nxt_s  = epc_r;
                flush_nxt_s = 1'b1;
            end
            SEL_JUMP: begin
                addr_nxt_s  = jmp_target_s;
                flush_nxt_s = 1'b1;
            end
            SEL_BRANCH: begin
                addr_nxt_s  = rel_target_s;
                flush_nxt_s = 1'b1;
            end
            SEL_HOLD: begin
                addr_nxt_s   = addr_r;
                addr_d_nxt_s = addr_d_r;
            end
            SEL_SEQ: begin
                // Plain increment; wraps modulo 2^XLEN without error.
                addr_nxt_s = addr_r + STEP_BYTES;
            end
            default: begin
                addr_nxt_s   = RESET_VECTOR;
                addr_d_nxt_s = RESET_VECTOR;
                epc_nxt_s    = epc_r;
                flush_nxt_s  = 1'b0;
            end
        endcase
    end

    // Register update with synchronous reset.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            addr_r     <= RESET_VECTOR;
            addr_d_r   <= RESET_VECTOR;
            epc_r      <= {XLEN{1'b0}};
            flush_r    <= 1'b0;
            misalign_r <= 1'b0;
        end else begin
            addr_r     <= addr_nxt_s;
            addr_d_r   <= addr_d_nxt_s;
            epc_r      <= epc_nxt_s;
            flush_r    <= flush_nxt_s;
            misalign_r <= misalign_s;
        end
    end

    assign addr     = addr_r;
    assign addr_d   = addr_d_r;
    assign epc      = epc_r;
    assign flush    = flush_r;
    assign misalign = misalign_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed scenarios plus randomized stimulus against a
// behavioural reference model of the PC sequencer.
module tb_pc_sequencer;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        stall;
    logic        br_valid;
    logic [2:0]  br_cond;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] offset;
    logic        jmp_valid;
    logic        jmp_kind;
    logic        trap_req;
    logic        mret;
    logic [31:0] addr;
    logic [31:0] addr_d;
    logic        flush;
    logic [31:0] epc;
    logic        misalign;

    int total = 0;
    int bad   = 0;

    // Reference model state.
    bit [31:0] m_addr, m_addr_d, m_epc;
    bit        m_flush, m_mis;

    pc_sequencer #(
        .XLEN         (32),
        .RESET_VECTOR (32'h0000_0240),
        .MTVEC        (32'h0000_0100)
    ) dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .stall     (stall),
        .br_valid  (br_valid),
        .br_cond   (br_cond),
        .rs1_val   (rs1_val),
        .rs2_val   (rs2_val),
        .offset    (offset),
        .jmp_valid (jmp_valid),
        .jmp_kind  (jmp_kind),
        .trap_req  (trap_req),
        .mret      (mret),
        .addr      (addr),
        .addr_d    (addr_d),
        .flush     (flush),
        .epc       (epc),
        .misalign  (misalign)
    );

    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic bit ref_taken(input bit [2:0] c, input bit [31:0] a, input bit [31:0] b);
        case (c)
            3'b000:  return a == b;
            3'b001:  return a != b;
            3'b100:  return $signed(a) <  $signed(b);
            3'b101:  return $signed(a) >= $signed(b);
            3'b110:  return a <  b;
            3'b111:  return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    task automatic clr();
        Reset = 1'b0; stall = 1'b0; br_valid = 1'b0; br_cond = 3'b000;
        rs1_val = 32'h0; rs2_val = 32'h0; offset = 32'h0;
        jmp_valid = 1'b0; jmp_kind = 1'b0; trap_req = 1'b0; mret = 1'b0;
    endtask

    // Advance the model by the rules, clock the DUT, compare all outputs.
    task automatic tick();
        bit [31:0] tgt;
        bit        have, mis;
        bit [31:0] n_addr, n_addr_d, n_epc;
        bit        n_flush;
        have = 1'b0;
        tgt  = 32'h0;
        if (jmp_valid) begin
            have = 1'b1;
            tgt  = jmp_kind ? ((rs1_val + offset) & 32'hFFFF_FFFE) : (m_addr_d + offset);
        end else if (br_valid && ref_taken(br_cond, rs1_val, rs2_val)) begin
            have = 1'b1;
            tgt  = m_addr_d + offset;
        end
        mis = have && (tgt % 4 != 0);
        n_epc = m_epc;
        if (Reset) begin
            n_addr = 32'h240; n_addr_d = 32'h240; n_epc = 32'h0; n_flush = 1'b0; mis = 1'b0;
        end else if (trap_req || mis) begin
            n_addr = 32'h100; n_addr_d = m_addr; n_epc = m_addr_d; n_flush = 1'b1;
        end else if (mret) begin
            n_addr = m_epc; n_addr_d = m_addr; n_flush = 1'b1;
        end else if (have) begin
            n_addr = tgt; n_addr_d = m_addr; n_flush = 1'b1;
        end else if (stall) begin
            n_addr = m_addr; n_addr_d = m_addr_d; n_flush = 1'b0;
        end else begin
            n_addr = m_addr + 32'd4; n_addr_d = m_addr; n_flush = 1'b0;
        end
        @(posedge CLK);
        #1;
        m_addr = n_addr; m_addr_d = n_addr_d; m_epc = n_epc; m_flush = n_flush; m_mis = mis;
        check_val("addr",     addr,            m_addr);
        check_val("addr_d",   addr_d,          m_addr_d);
        check_val("epc",      epc,             m_epc);
        check_val("flush",    {31'h0, flush},    {31'h0, m_flush});
        check_val("misalign", {31'h0, misalign}, {31'h0, m_mis});
    endtask

    task automatic do_reset();
        clr(); Reset = 1'b1; tick(); clr();
    endtask

    bit [31:0] saved;

    initial begin
        clr();
        // Reset and free-running fetch.
        do_reset();
        check_val("rst_addr", addr, 32'h240);
        check_val("rst_epc", epc, 32'h0);
        tick(); check_val("seq1", addr, 32'h244);
        tick(); check_val("seq2", addr, 32'h248);
        tick(); check_val("seq3", addr, 32'h24C);
        check_val("seq_flush", {31'h0, flush}, 32'h0);

        // BNE taken back by 8 from addr_d=0x248.
        check_val("bne_pre_addr_d", addr_d, 32'h248);
        br_valid = 1'b1; br_cond = 3'b001; rs1_val = 32'd5; rs2_val = 32'd3; offset = 32'hFFFF_FFF8;
        tick(); clr();
        check_val("bne_addr", addr, 32'h240);
        check_val("bne_flush", {31'h0, flush}, 32'h1);
        tick();
        check_val("bne_flush_end", {31'h0, flush}, 32'h0);

        // Same case with BEQ: not taken.
        do_reset(); tick(); tick(); tick();
        br_valid = 1'b1; br_cond = 3'b000; rs1_val = 32'd5; rs2_val = 32'd3; offset = 32'hFFFF_FFF8;
        tick(); clr();
        check_val("beq_addr", addr, 32'h250);
        check_val("beq_flush", {31'h0, flush}, 32'h0);

        // Signed vs unsigned compares.
        br_valid = 1'b1; rs1_val = 32'hFFFF_FFFF; rs2_val = 32'd1; offset = 32'h20;
        br_cond = 3'b100; tick(); check_val("blt_taken", {31'h0, flush}, 32'h1);
        br_cond = 3'b110; tick(); check_val("bltu_not", {31'h0, flush}, 32'h0);
        br_cond = 3'b111; tick(); check_val("bgeu_taken", {31'h0, flush}, 32'h1);
        clr();

        // JALR clears bit 0 of the target.
        jmp_valid = 1'b1; jmp_kind = 1'b1; rs1_val = 32'h301; offset = 32'h10;
        tick(); clr();
        check_val("jalr_addr", addr, 32'h310);

        // Misaligned JAL traps.
        do_reset(); tick(); tick(); tick();
        jmp_valid = 1'b1; jmp_kind = 1'b0; offset = 32'h2;
        tick(); clr();
        check_val("mis_addr", addr, 32'h100);
        check_val("mis_epc", epc, 32'h248);
        check_val("mis_pulse", {31'h0, misalign}, 32'h1);
        tick();
        check_val("mis_pulse_end", {31'h0, misalign}, 32'h0);

        // Trap beats jump, then mret returns to epc.
        saved = addr_d;
        trap_req = 1'b1; jmp_valid = 1'b1; offset = 32'h40;
        tick(); clr();
        check_val("trap_addr", addr, 32'h100);
        check_val("trap_epc", epc, saved);
        tick();
        mret = 1'b1; tick(); clr();
        check_val("mret_addr", addr, saved);
        check_val("mret_flush", {31'h0, flush}, 32'h1);

        // Trap and mret together: trap wins.
        saved = addr_d;
        trap_req = 1'b1; mret = 1'b1; tick(); clr();
        check_val("trap_mret_addr", addr, 32'h100);
        check_val("trap_mret_epc", epc, saved);

        // Stall for 3 cycles at 0x250, then resume.
        do_reset(); tick(); tick(); tick(); tick();
        check_val("stall_start", addr, 32'h250);
        stall = 1'b1; tick(); tick(); tick();
        check_val("stall_hold", addr, 32'h250);
        clr(); tick();
        check_val("stall_resume", addr, 32'h254);

        // Reset in the second stall cycle.
        stall = 1'b1; tick();
        Reset = 1'b1; tick(); clr();
        check_val("stall_rst_addr", addr, 32'h240);
        check_val("stall_rst_flush", {31'h0, flush}, 32'h0);

        // Wrap-around at the top of the address space.
        jmp_valid = 1'b1; jmp_kind = 1'b1; rs1_val = 32'hFFFF_FFF0; offset = 32'hC;
        tick(); clr();
        check_val("wrap_top", addr, 32'hFFFF_FFFC);
        tick();
        check_val("wrap_zero", addr, 32'h0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            int sel;
            clr();
            Reset     = ($urandom_range(0, 99) < 1);
            trap_req  = ($urandom_range(0, 99) < 3);
            mret      = ($urandom_range(0, 99) < 4);
            jmp_valid = ($urandom_range(0, 99) < 10);
            jmp_kind  = 1'($urandom_range(0, 1));
            br_valid  = ($urandom_range(0, 99) < 30);
            stall     = ($urandom_range(0, 99) < 20);
            br_cond   = 3'($urandom_range(0, 7));
            rs1_val   = $urandom;
            rs2_val   = ($urandom_range(0, 3) == 0) ? rs1_val : $urandom;
            sel = $urandom_range(0, 99);
            if (sel < 80) begin
                offset = 32'(($urandom_range(0, 63) - 32) * 4);
            end else begin
                offset = $urandom;
            end
            if (jmp_kind && $urandom_range(0, 1) == 1) begin
                rs1_val = {rs1_val[31:2], 2'($urandom_range(0, 1))};
            end
            tick();
        end
        clr();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
